cmp_sched: RTL

CMP_SCHED -- requirements
Module: cmp_sched

---
 rtl/cmp_sched_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/cmp_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cmp_sched_pkg.sv
// rtl/cmp_sched_pkg.sv - shared types and result codes for the serial compare scheduler
package cmp_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      RESULT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      REL_EQ = 2'd0,
      REL_LT = 2'd1,
      REL_GT = 2'd2
   } rel_e;

   localparam logic [2:0] CODE_LT   = 3'b100;
   localparam logic [2:0] CODE_EQ   = 3'b010;
   localparam logic [2:0] CODE_GT   = 3'b001;
   localparam logic [2:0] CODE_NONE = 3'b000;

   function automatic logic [2:0] rel_to_code(rel_e rel);
      case (rel)
         REL_LT:  return CODE_LT;
         REL_GT:  return CODE_GT;
         default: return CODE_EQ;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first active request at or after the pointer
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] pointer,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index
);

   always_comb begin
      logic [IW-1:0] j;
      logic          found;
      j     = '0;
      found = 1'b0;
      grant = '0;
      index = '0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(pointer) + k) % N);
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            index    = j;
         end
      end
   end

endmodule

// File: rtl/cmp_sched.sv
// rtl/cmp_sched.sv - round-robin scheduler feeding a bit-serial magnitude comparator
module cmp_sched
   import cmp_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*W-1:0]         req_a,
   input  logic [N_REQ*W-1:0]         req_b,
   output logic                       ser_a,
   output logic                       ser_b,
   output logic                       ser_frame,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [$clog2(N_REQ)-1:0]   res_id,
   output logic [2:0]                 res_code
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(W);

   state_e        state_q, state_d;
   rel_e          rel_q, rel_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] id_q, id_d;
   logic [IW-1:0] res_id_q, res_id_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;

   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    gnt_idx;

   rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
      .req     (req_valid),
      .pointer (ptr_q),
      .grant   (grant),
      .index   (gnt_idx)
   );

   always_comb begin
      state_d   = state_q;
      rel_d     = rel_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      res_id_d  = res_id_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      req_ready = '0;
      ser_a     = 1'b0;
      ser_b     = 1'b0;
      ser_frame = 1'b0;
      res_valid = 1'b0;
      res_code  = CODE_NONE;
      case (state_q)
         IDLE: begin
            // Gated by rst_n so the grant stays low while reset is held.
            if (rst_n && (|grant)) begin
               req_ready = grant;
               a_d       = req_a[gnt_idx*W +: W];
               b_d       = req_b[gnt_idx*W +: W];
               id_d      = gnt_idx;
               ptr_d     = (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
               cnt_d     = '0;
               rel_d     = REL_EQ;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            ser_a     = a_q[cnt_q];
            ser_b     = b_q[cnt_q];
            ser_frame = (cnt_q == '0);
            // LSB first: a later (more significant) difference overrides earlier ones.
            if (ser_a != ser_b)
               rel_d = ser_a ? REL_GT : REL_LT;
            if (cnt_q == CW'(W-1)) begin
               cnt_d    = '0;
               res_id_d = id_q;
               state_d  = RESULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESULT: begin
            res_valid = 1'b1;
            res_code  = rel_to_code(rel_q);
            if (res_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign res_id = res_id_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rel_q    <= REL_EQ;
         ptr_q    <= '0;
         id_q     <= '0;
         res_id_q <= '0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         state_q  <= state_d;
         rel_q    <= rel_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         res_id_q <= res_id_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
      end
   end

endmodule
